e203_ifu_bht: RTL and testbench

Bimodal branch history table supplying the predicted-taken bit for conditional branches (Bxx) fetched in the IFU, and trained by resolved outcomes returned from commit. Its prediction becomes the `bjp_prdt` bit that travels down the pipe to the commit-stage branch resolver. The resolver's resolved bit and misprediction status come back here as the update. The block also keeps saturating hit and miss performance counters.

---
 rtl/e203_ifu_bht_if.sv | 45 ++++
 rtl/e203_ifu_bht.sv | 176 +++++++++++++++++
 tb/tb_e203_ifu_bht.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/e203_ifu_bht_if.sv
// Bundle of the lookup, commit-update, clear and performance-counter signals
// of the IFU branch history table. The IFU/commit side uses the master
// modport; the BHT itself uses the slave modport.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

interface e203_ifu_bht_if #(
    parameter int PC_W  = `E203_PC_SIZE,
    parameter int CNT_W = 32
);
    // Lookup side: prdt_i_vld qualifies prdt_i_pc, answer is combinational.
    logic             prdt_i_vld;
    logic [PC_W-1:0]  prdt_i_pc;
    logic             prdt_o_taken;

    // Commit-update side: one pulse of upd_i_vld per committed Bxx, no
    // backpressure (always accepted).
    logic             upd_i_vld;
    logic [PC_W-1:0]  upd_i_pc;
    logic             upd_i_taken;
    logic             upd_i_mispred;

    // Synchronous clears.
    logic             bht_clr;
    logic             perf_clr;

    // Performance counters.
    logic [CNT_W-1:0] perf_o_hit;
    logic [CNT_W-1:0] perf_o_mis;

    modport master (
        output prdt_i_vld, prdt_i_pc,
        output upd_i_vld, upd_i_pc, upd_i_taken, upd_i_mispred,
        output bht_clr, perf_clr,
        input  prdt_o_taken, perf_o_hit, perf_o_mis
    );

    modport slave (
        input  prdt_i_vld, prdt_i_pc,
        input  upd_i_vld, upd_i_pc, upd_i_taken, upd_i_mispred,
        input  bht_clr, perf_clr,
        output prdt_o_taken, perf_o_hit, perf_o_mis
    );
endinterface

// File: rtl/e203_ifu_bht.sv
// Bimodal branch history table for conditional branches fetched by the IFU.
// 2^BHT_IDX_W two-bit saturating counters indexed by pc[BHT_IDX_W:1], one
// registered update stage with lookup bypass, and saturating hit/miss
// performance counters.
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_ifu_bht #(
    parameter int BHT_IDX_W = 4,
    parameter int PC_W      = `E203_PC_SIZE,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    e203_ifu_bht_if.slave   bus
);

    localparam int          ENTRIES  = 1 << BHT_IDX_W;
    localparam logic [1:0]  CNT_WNT  = 2'b01;   // reset / clear value (weak not-taken)
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Two-bit saturating step: +1 when taken, -1 when not taken.
    // ------------------------------------------------------------------
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic inc);
        logic [1:0] nxt;
        nxt = cur;
        if (inc) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           cnt_q [ENTRIES];
    logic [1:0]           cnt_d [ENTRIES];

    logic                 upd_vld_q, upd_vld_d;
    logic [BHT_IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic                 upd_taken_q, upd_taken_d;

    logic [CNT_W-1:0]     hit_q, hit_d;
    logic [CNT_W-1:0]     mis_q, mis_d;

    // Indices and the counter value the pending update will write.
    logic [BHT_IDX_W-1:0] prdt_idx;
    logic [BHT_IDX_W-1:0] upd_in_idx;
    logic [1:0]           upd_next;

    assign prdt_idx   = bus.prdt_i_pc[BHT_IDX_W:1];
    assign upd_in_idx = bus.upd_i_pc[BHT_IDX_W:1];

    // PC bits outside the index field do not take part in the table.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0,
                              bus.prdt_i_pc[PC_W-1:BHT_IDX_W+1], bus.prdt_i_pc[0],
                              bus.upd_i_pc[PC_W-1:BHT_IDX_W+1],  bus.upd_i_pc[0]};

    // Pending next value. The array is read at write time, so a second
    // back-to-back update to the same entry sees the first one already
    // written and the chain is preserved.
    always_comb begin
        upd_next = sat_step(cnt_q[upd_idx_q], upd_taken_q);
    end

    // ------------------------------------------------------------------
    // Lookup: combinational, bypassing the pending update on an index hit;
    // forced low while the table is being cleared or when not strobed.
    // ------------------------------------------------------------------
    always_comb begin
        bus.prdt_o_taken = 1'b0;
        if (bus.prdt_i_vld && !bus.bht_clr) begin
            if (upd_vld_q && (prdt_idx == upd_idx_q)) begin
                bus.prdt_o_taken = upd_next[1];
            end else begin
                bus.prdt_o_taken = cnt_q[prdt_idx][1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Update stage capture: a clear drops both the pending and the incoming
    // update. Index/direction only reload when a new update arrives.
    // ------------------------------------------------------------------
    always_comb begin
        upd_vld_d   = bus.upd_i_vld & ~bus.bht_clr;
        upd_idx_d   = upd_idx_q;
        upd_taken_d = upd_taken_q;
        if (bus.upd_i_vld) begin
            upd_idx_d   = upd_in_idx;
            upd_taken_d = bus.upd_i_taken;
        end
    end

    // Update stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_vld_q   <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            upd_vld_q   <= upd_vld_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // ------------------------------------------------------------------
    // Table next state: clear wins over the pending write.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (bus.bht_clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_d[i] = CNT_WNT;
            end
        end else if (upd_vld_q) begin
            cnt_d[upd_idx_q] = upd_next;
        end
    end

    // Table register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters: counted at update arrival (not after the stage),
    // saturating, perf_clr overrides a same-cycle increment, unaffected by
    // bht_clr.
    // ------------------------------------------------------------------
    always_comb begin
        hit_d = hit_q;
        mis_d = mis_q;
        if (bus.perf_clr) begin
            hit_d = '0;
            mis_d = '0;
        end else if (bus.upd_i_vld) begin
            if (bus.upd_i_mispred) begin
                if (mis_q != CNT_MAX) mis_d = mis_q + 1'b1;
            end else begin
                if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            mis_q <= '0;
        end else begin
            hit_q <= hit_d;
            mis_q <= mis_d;
        end
    end

    assign bus.perf_o_hit = hit_q;
    assign bus.perf_o_mis = mis_q;

endmodule

// File: tb/tb_e203_ifu_bht.sv
// Directed bench for e203_ifu_bht. Performance counters are built 3 bits
// wide here so saturation is reachable with a handful of updates.
module tb_e203_ifu_bht;

    localparam int IDX_W = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    e203_ifu_bht_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    e203_ifu_bht #(
        .BHT_IDX_W(IDX_W),
        .PC_W     (PC_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock: 20 ns period.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.upd_i_vld     = 1'b0;
        bus.upd_i_pc      = '0;
        bus.upd_i_taken   = 1'b0;
        bus.upd_i_mispred = 1'b0;
        bus.bht_clr       = 1'b0;
        bus.perf_clr      = 1'b0;
        bus.prdt_i_vld    = 1'b0;
        bus.prdt_i_pc     = '0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic mis);
        bus.upd_i_vld     = 1'b1;
        bus.upd_i_pc      = pc;
        bus.upd_i_taken   = taken;
        bus.upd_i_mispred = mis;
    endtask

    // Combinational lookup, checked 1 ns after driving the PC.
    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        bus.prdt_i_vld = 1'b1;
        bus.prdt_i_pc  = pc;
        #1;
        chk(tag, {31'b0, bus.prdt_o_taken}, {31'b0, exp});
    endtask

    task automatic perf(input string tag, input logic [31:0] hit, input logic [31:0] mis);
        chk({tag, "_hit"}, {29'b0, bus.perf_o_hit}, hit);
        chk({tag, "_mis"}, {29'b0, bus.perf_o_mis}, mis);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        look("rst_look_in_reset", 32'h8000_0010, 1'b0);
        rst_n = 1'b1;
        tick();
        look("rst_look", 32'h8000_0010, 1'b0);
        bus.prdt_i_vld = 1'b0;
        #1;
        chk("rst_vld0", {31'b0, bus.prdt_o_taken}, 32'd0);
        perf("rst", 0, 0);

        // ---------------- training idx 8 ----------------
        // cycle N: taken update, not yet visible
        upd(32'h8000_0010, 1'b1, 1'b1);
        look("n_not_visible", 32'h8000_0010, 1'b0);
        tick();
        // N+1: second taken update, bypass shows 01->10
        upd(32'h8000_0010, 1'b1, 1'b0);
        look("n1_bypass", 32'h8000_0010, 1'b1);
        perf("n1", 0, 1);
        tick();
        // N+2: bypass shows 10->11
        idle();
        look("n2_bypass", 32'h8000_0010, 1'b1);
        perf("n2", 1, 1);
        tick();
        // N+3: array holds 11; first of three not-taken
        look("n3_array", 32'h8000_0010, 1'b1);
        upd(32'h8000_0010, 1'b0, 1'b1);
        tick();
        upd(32'h8000_0010, 1'b0, 1'b1);
        look("nt1_bypass_10", 32'h8000_0010, 1'b1);
        tick();
        upd(32'h8000_0010, 1'b0, 1'b1);
        look("nt2_bypass_01", 32'h8000_0010, 1'b0);
        tick();
        idle();
        look("nt3_bypass_00", 32'h8000_0010, 1'b0);
        tick();
        look("nt_array_00", 32'h8000_0010, 1'b0);
        // one taken from 00 gives 01: still predicts 0 (would be 1 from 01)
        upd(32'h8000_0010, 1'b1, 1'b0);
        tick();
        idle();
        look("from00_to01", 32'h8000_0010, 1'b0);
        perf("train", 2, 4);
        tick();

        // ---------------- aliasing ----------------
        upd(32'h0000_0020, 1'b1, 1'b1);
        tick();
        upd(32'h0000_0020, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        look("alias_0x40", 32'h0000_0040, 1'b1);
        look("alias_0x21_bit0", 32'h0000_0021, 1'b1);
        look("alias_0x22_idx1", 32'h0000_0022, 1'b0);
        perf("alias", 3, 5);

        // ---------------- bht_clr with same-cycle update ----------------
        bus.bht_clr = 1'b1;
        upd(32'h0000_0020, 1'b1, 1'b0);
        look("clr_forces_0", 32'h0000_0020, 1'b0);
        tick();
        idle();
        look("clr_idx0_dropped", 32'h0000_0020, 1'b0);
        look("clr_idx8", 32'h8000_0010, 1'b0);
        perf("clr", 4, 5);
        // entry is 01 (not 00): one taken lifts it to predict 1
        upd(32'h0000_0020, 1'b1, 1'b0);
        tick();
        idle();
        look("clr_entry_is_01", 32'h0000_0020, 1'b1);
        tick();
        look("clr_entry_10", 32'h0000_0020, 1'b1);
        perf("post_clr", 5, 5);

        // ---------------- counter saturation ----------------
        upd(32'h0000_0002, 1'b0, 1'b1);
        tick();
        perf("sat_m6", 5, 6);
        upd(32'h0000_0002, 1'b0, 1'b1);
        tick();
        chk("sat_m7a", {29'b0, bus.perf_o_mis}, 32'd7);
        upd(32'h0000_0002, 1'b0, 1'b1);
        tick();
        chk("sat_m7b", {29'b0, bus.perf_o_mis}, 32'd7);
        upd(32'h0000_0002, 1'b0, 1'b1);
        tick();
        chk("sat_m7c", {29'b0, bus.perf_o_mis}, 32'd7);
        upd(32'h0000_0004, 1'b1, 1'b0);
        tick();
        tick();
        chk("sat_h7a", {29'b0, bus.perf_o_hit}, 32'd7);
        tick();
        perf("sat_h7b", 7, 7);
        bus.perf_clr = 1'b1;
        upd(32'h0000_0002, 1'b0, 1'b1);
        tick();
        perf("perf_clr_mis", 0, 0);
        upd(32'h0000_0004, 1'b1, 1'b0);
        bus.perf_clr = 1'b0;
        tick();
        idle();
        perf("after_clr_hit", 1, 0);

        // ---------------- async reset with pending update ----------------
        upd(32'h0000_0020, 1'b1, 1'b1);
        tick();
        idle();
        look("ar_pending", 32'h0000_0020, 1'b1);
        perf("ar_before", 1, 1);
        rst_n = 1'b0;
        look("ar_look", 32'h0000_0020, 1'b0);
        perf("ar_during", 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        look("ar_lost", 32'h0000_0020, 1'b0);
        look("ar_idx8", 32'h8000_0010, 1'b0);
        perf("ar_after", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
